// File: rtl/multi_button_debounce.sv
// multi_button_debounce: N-channel button synchroniser and debouncer with press/release pulses; optional long-press/auto-repeat via DEBOUNCE_LONG_PRESS_EN
module multi_button_debounce #(
  parameter int NCH = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn_raw,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] press_p,
  output logic [NCH-1:0] release_p,
  output logic [NCH-1:0] long_p
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  logic [NCH-1:0] meta_q, meta_d, sync_q, level_q, level_d, press_q, press_d, release_q, release_d;
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  // polarity fix-up, then per-channel stability count; any agreement with the current level restarts it
  always_comb begin
    meta_d = btn_raw ^ {NCH{ACTIVE_LOW}};
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = (sync_q[i] != level_q[i] && cnt_q[i] != CNT_LAST) ? cnt_q[i] + 1'b1 : '0;
      level_d[i] = (sync_q[i] != level_q[i] && cnt_q[i] == CNT_LAST) ? sync_q[i] : level_q[i];
      press_d[i] = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];
    end
  end
  // two-flop synchroniser, counters and registered level/pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      level_q <= '0;
      press_q <= '0;
      release_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign btn_level = level_q;
  assign press_p = press_q;
  assign release_p = release_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);
  logic [HW-1:0] hold_q [NCH];
  logic [HW-1:0] hold_d [NCH];
  logic [NCH-1:0] long_q, long_d;
  // hold time counter; reload after each pulse gives the repeat period, and the release edge suppresses the pulse
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hold_d[i] = !level_q[i] ? '0 : (hold_q[i] == HOLD_LAST ? HOLD_RELOAD : hold_q[i] + 1'b1);
      long_d[i] = level_q[i] & level_d[i] & (hold_q[i] == HOLD_LAST);
    end
  end
  // hold counters and registered long-press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < NCH; i++) hold_q[i] <= hold_d[i];
    end
  end
  assign long_p = long_q;
`else
  logic unused_hold;
  assign unused_hold = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign long_p = '0;
`endif
endmodule

// File: tb/tb_multi_button_debounce.sv
// tb_multi_button_debounce: directed plus random stimulus against a timestamp-based reference model
module tb_multi_button_debounce;
  localparam int NCH = 4, ST = 4, HOLD = 20, REP = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [NCH-1:0] btn_raw = '1, btn_level, press_p, release_p, long_p;
  int n_checks = 0, n_fail = 0;
  logic [NCH-1:0] p0 = '0, p1 = '0, m_level = '0, m_press = '0, m_release = '0, m_long = '0;
  int k = 0;
  int last_agree [NCH], last_evt [NCH], rise [NCH];
  int pc [NCH], rc [NCH], lc [NCH];

  multi_button_debounce #(.NCH(NCH), .STABLE_CYCLES(ST), .ACTIVE_LOW(1'b0),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_p(press_p), .release_p(release_p), .long_p(long_p));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // level flips once the synchronised input has disagreed for ST edges since both the last agreement and the last flip/reset
  task automatic model_edge();
    logic [NCH-1:0] s;
    int since;
    k++;
    m_press = '0; m_release = '0; m_long = '0;
    if (rst) begin
      p0 = '0; p1 = '0; m_level = '0;
      for (int i = 0; i < NCH; i++) begin last_agree[i] = k; last_evt[i] = k; end
    end else begin
      s = p1; p1 = p0; p0 = btn_raw;
      for (int i = 0; i < NCH; i++) begin
        since = last_agree[i] > last_evt[i] ? last_agree[i] : last_evt[i];
        if (s[i] == m_level[i]) last_agree[i] = k;
        else if (k - since >= ST) begin
          m_level[i] = s[i]; last_evt[i] = k;
          m_press[i] = s[i]; m_release[i] = !s[i];
          if (s[i]) rise[i] = k;
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        if (m_level[i] && k - rise[i] >= HOLD && (k - rise[i] - HOLD) % REP == 0) m_long[i] = 1'b1;
`endif
      end
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] b);
    rst = r; btn_raw = b;
    @(posedge clk);
    model_edge();
    #1;
    check("level", btn_level, m_level);
    check("press", press_p, m_press);
    check("release", release_p, m_release);
    check("long", long_p, m_long);
    for (int i = 0; i < NCH; i++) begin
      pc[i] += int'(press_p[i]); rc[i] += int'(release_p[i]); lc[i] += int'(long_p[i]);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NCH; i++) begin pc[i] = 0; rc[i] = 0; lc[i] = 0; end
  endtask

  task automatic hold(input logic [NCH-1:0] b, input int n);
    for (int j = 0; j < n; j++) step(1'b0, b);
  endtask

  initial begin
    int pct;
    logic [NCH-1:0] cur;
    for (int i = 0; i < NCH; i++) rise[i] = 0;
    clr_counts();
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 4'hF);
      check("rst_level", btn_level, 4'h0);
    end
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 4'hF);
      if (j == 6) begin
        check("rst_press6", press_p, 4'hF);
        check("rst_level6", btn_level, 4'hF);
      end
      if (j == 5) check("rst_level5", btn_level, 4'h0);
    end
    hold(4'h0, 10);
    clr_counts();
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    check("ch0_press_cnt", 4'(pc[0]), 4'd1);
    check("ch0_rel_cnt", 4'(rc[0]), 4'd1);
    check("other_press_cnt", 4'(pc[1] + pc[2] + pc[3]), 4'd0);
    clr_counts();
    step(1'b0, 4'b0010); step(1'b0, 4'b0000); step(1'b0, 4'b0010);
    step(1'b0, 4'b0000); step(1'b0, 4'b0010);
    hold(4'b0010, 12);
    check("bounce_press_cnt", 4'(pc[1]), 4'd1);
    check("bounce_rel_cnt", 4'(rc[1]), 4'd0);
    hold(4'b0011, 10);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 4'b1110);
      if (j == 6) begin
        check("sim_press", press_p, 4'b1100);
        check("sim_release", release_p, 4'b0001);
      end
    end
    hold(4'b1111, 10);
    clr_counts();
    hold(4'b1110, 3);
    hold(4'b1111, 10);
    check("glitch3_pulses", 4'(pc[0] + rc[0]), 4'd0);
    check("glitch3_level", btn_level, 4'b1111);
    hold(4'b1110, 4);
    hold(4'b1111, 12);
    check("glitch4_rel", 4'(rc[0]), 4'd1);
    check("glitch4_press", 4'(pc[0]), 4'd1);
    hold(4'b0000, 10);
    clr_counts();
    hold(4'b0010, 40);
    hold(4'b0000, 20);
`ifdef DEBOUNCE_LONG_PRESS_EN
    check("long_cnt", 4'(lc[1]), 4'd3);
`else
    check("long_cnt", 4'(lc[1]), 4'd0);
`endif
    cur = '0;
    pct = 5;
    for (int j = 0; j < 3000; j++) begin
      if (j % 40 == 0) pct = (j / 40) % 3 == 0 ? 2 : ((j / 40) % 3 == 1 ? 8 : 40);
      for (int i = 0; i < NCH; i++) if ($urandom_range(99) < pct) cur[i] = ~cur[i];
      step($urandom_range(199) == 0, cur);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
